// File: rtl/cache_ctrl_pkg.sv
// cache_ctrl_pkg: shared state encoding and parameter helpers for the cache controller.
package cache_ctrl_pkg;

   typedef enum logic [2:0] {
      ERR   = 3'd0,
      IDLE  = 3'd1,
      COMP  = 3'd2,
      WB    = 3'd3,
      FILL  = 3'd4,
      DRAIN = 3'd5,
      RETRY = 3'd6
   } state_e;

   localparam int DEF_WORDS = 4;
   localparam int DEF_OFF_W = $clog2(DEF_WORDS);

   function automatic int off_w(input int words);
      return $clog2(words);
   endfunction

   function automatic bit ways_legal(input int ways);
      return ways == 1 || ways == 2;
   endfunction

endpackage

// File: rtl/cache_fill_tracker.sv
// cache_fill_tracker: MEM_LAT-deep shift register of {valid, offset} for outstanding line-fill reads.
module cache_fill_tracker
   import cache_ctrl_pkg::*;
#(
   parameter int OFF_W   = DEF_OFF_W,
   parameter int MEM_LAT = 2
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [OFF_W-1:0] push_offset,
   output logic             emerge,
   output logic [OFF_W-1:0] emerge_offset,
   output logic             empty
);

   localparam int SR_W = MEM_LAT * OFF_W;
   // every stage but the last; empty means nothing is left once this cycle's entry emerges
   localparam logic [MEM_LAT-1:0] PEND = {MEM_LAT{1'b1}} >> 1;

   logic [MEM_LAT-1:0]            v_q, v_d;
   logic [MEM_LAT-1:0][OFF_W-1:0] off_q, off_d;

   always_comb begin
      v_d   = MEM_LAT'({v_q, push});
      off_d = SR_W'({off_q, push_offset});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q   <= '0;
         off_q <= '0;
      end else begin
         v_q   <= v_d;
         off_q <= off_d;
      end
   end

   assign emerge        = v_q[MEM_LAT-1];
   assign emerge_offset = off_q[MEM_LAT-1];
   assign empty         = ~|(v_q & PEND);

endmodule

// File: rtl/cache_ctrl_fsm.sv
// cache_ctrl_fsm: 1/2-way cache controller FSM (compare, victim, write-back, fill, retry).
// Optional hit/miss counters are built when CACHE_CTRL_PERF_CNT_EN is defined.
module cache_ctrl_fsm
   import cache_ctrl_pkg::*;
#(
   parameter  int ADDR_W  = 16,
   parameter  int WORDS   = 4,
   parameter  int MEM_LAT = 2,
   parameter  int WAYS    = 2,
   parameter  int IDX_W   = 4,
   localparam int OFF_W   = $clog2(WORDS),
   localparam int TAG_W   = ADDR_W - OFF_W - 1 - IDX_W
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WAYS-1:0]   c_hit,
   input  logic [WAYS-1:0]   c_valid,
   input  logic [WAYS-1:0]   c_dirty,
   input  logic [TAG_W-1:0]  c_tag,
   output logic [WAYS-1:0]   c_en,
   output logic              c_comp,
   output logic              c_write,
   output logic              c_valid_in,
   output logic [OFF_W-1:0]  c_offset,
   output logic              c_src_mem,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_stall,
   output logic              done,
   output logic              stall,
   output logic              cache_hit,
   output logic              err,
   output logic [15:0]       hit_cnt,
   output logic [15:0]       miss_cnt
);

   if (!ways_legal(WAYS)) begin : g_bad_ways
      $error("cache_ctrl_fsm: WAYS must be 1 or 2");
   end

   state_e              state_q, state_d;
   logic [ADDR_W-1:1]   addr_q, addr_d;
   logic                op_wr_q, op_wr_d;
   logic [OFF_W-1:0]    cnt_q, cnt_d;
   logic                vic_q, vic_d, vptr_q, vptr_d, sel, hit, push, emerge, empty;
   logic [OFF_W-1:0]    emerge_off;
   logic [WAYS-1:0]     vic_oh;
   logic                unused_addr0;

   assign unused_addr0 = addr[0];
   assign hit    = |(c_hit & c_valid);
   // lowest invalid way first, otherwise round-robin pointer
   assign sel    = !c_valid[0] ? 1'b0 : (WAYS == 2 && !c_valid[WAYS-1]) ? 1'b1 : vptr_q;
   assign vic_oh = WAYS'(1) << vic_q;

   cache_fill_tracker #(.OFF_W(OFF_W), .MEM_LAT(MEM_LAT)) u_trk (
      .clk(clk), .rst_n(rst_n), .push(push), .push_offset(cnt_q),
      .emerge(emerge), .emerge_offset(emerge_off), .empty(empty)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      op_wr_d    = op_wr_q;
      cnt_d      = cnt_q;
      vic_d      = vic_q;
      vptr_d     = vptr_q;
      c_en       = '0;
      c_comp     = 1'b0;
      c_write    = 1'b0;
      c_valid_in = 1'b0;
      c_offset   = addr_q[OFF_W:1];
      c_src_mem  = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      mem_addr   = '0;
      done       = 1'b0;
      stall      = 1'b1;
      cache_hit  = 1'b0;
      err        = 1'b0;
      push       = 1'b0;
      case (state_q)
         IDLE: begin
            stall = 1'b0;
            if (rd && wr) state_d = ERR;
            else if (rd || wr) begin
               addr_d  = addr[ADDR_W-1:1];
               op_wr_d = wr;
               state_d = COMP;
            end
         end
         COMP: begin
            c_comp  = 1'b1;
            c_write = op_wr_q;
            c_en    = '1;
            if (hit) begin
               done      = 1'b1;
               cache_hit = 1'b1;
               stall     = 1'b0;
               state_d   = IDLE;
            end else begin
               vic_d   = sel;
               cnt_d   = '0;
               state_d = (c_dirty[sel] && c_valid[sel]) ? WB : FILL;
            end
         end
         WB: begin
            c_en     = vic_oh;
            c_offset = cnt_q;
            mem_wr   = 1'b1;
            mem_addr = {c_tag, addr_q[OFF_W+IDX_W:OFF_W+1], cnt_q, 1'b0};
            if (!mem_stall) begin
               cnt_d   = cnt_q + 1'b1;
               state_d = (cnt_q == OFF_W'(WORDS-1)) ? FILL : WB;
            end
         end
         FILL: begin
            mem_rd   = 1'b1;
            mem_addr = {addr_q[ADDR_W-1:OFF_W+1], cnt_q, 1'b0};
            push     = !mem_stall;
            if (!mem_stall) begin
               cnt_d   = cnt_q + 1'b1;
               state_d = (cnt_q == OFF_W'(WORDS-1)) ? DRAIN : FILL;
            end
         end
         DRAIN: state_d = empty ? RETRY : DRAIN;
         RETRY: begin
            c_comp  = 1'b1;
            c_write = op_wr_q;
            c_en    = '1;
            done    = 1'b1;
            stall   = 1'b0;
            vptr_d  = (WAYS == 2) ? !vptr_q : 1'b0;
            state_d = IDLE;
         end
         ERR: err = 1'b1;
         default: state_d = ERR;
      endcase
      if (emerge) begin
         c_en       = vic_oh;
         c_write    = 1'b1;
         c_src_mem  = 1'b1;
         c_offset   = emerge_off;
         c_valid_in = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         op_wr_q <= 1'b0;
         cnt_q   <= '0;
         vic_q   <= 1'b0;
         vptr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         op_wr_q <= op_wr_d;
         cnt_q   <= cnt_d;
         vic_q   <= vic_d;
         vptr_q  <= vptr_d;
      end
   end

`ifdef CACHE_CTRL_PERF_CNT_EN
   logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = (state_q == COMP && hit && !(&hit_cnt_q)) ? hit_cnt_q + 1'b1 : hit_cnt_q;
      miss_cnt_d = (state_q == COMP && !hit && !(&miss_cnt_q)) ? miss_cnt_q + 1'b1 : miss_cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`else
   assign hit_cnt  = '0;
   assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// tb_cache_ctrl_fsm: scoreboard bench for cache_ctrl_fsm (WORDS=4, MEM_LAT=2, WAYS=2).
module tb_cache_ctrl_fsm;

   logic        clk = 1'b0, rst_n = 1'b0, rd = 1'b0, wr = 1'b0, mem_stall = 1'b0;
   logic [15:0] addr = '0;
   logic [1:0]  c_hit = '0, c_valid = '0, c_dirty = '0;
   logic [8:0]  c_tag = '0;
   logic [1:0]  c_en;
   logic [1:0]  c_offset;
   logic        c_comp, c_write, c_valid_in, c_src_mem, mem_rd, mem_wr;
   logic        done, stall, cache_hit, err;
   logic [15:0] mem_addr, hit_cnt, miss_cnt;

   int cyc = 0;
   int n_chk = 0, n_fail = 0;
   logic [15:0] q_rd[$], q_wr[$];
   logic [3:0]  q_ins[$];
   int          q_done[$];

   cache_ctrl_fsm #(.ADDR_W(16), .WORDS(4), .MEM_LAT(2), .WAYS(2), .IDX_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .rd(rd), .wr(wr), .addr(addr),
      .c_hit(c_hit), .c_valid(c_valid), .c_dirty(c_dirty), .c_tag(c_tag),
      .c_en(c_en), .c_comp(c_comp), .c_write(c_write), .c_valid_in(c_valid_in),
      .c_offset(c_offset), .c_src_mem(c_src_mem), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_addr(mem_addr), .mem_stall(mem_stall), .done(done), .stall(stall),
      .cache_hit(cache_hit), .err(err), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: unexpected event, mem_addr=%0h c_offset=%0h (cycle %0d)", name, mem_addr, c_offset, cyc);
   endtask

   // monitor: pops expectations whenever the DUT presents an observable event
   always @(negedge clk) begin
      logic [3:0] ie;
      int de;
      if (mem_wr) begin
         if (q_wr.size() == 0) unexpected("wb_strobe");
         else chk("wb_addr", mem_addr, q_wr.pop_front());
      end
      if (mem_rd && !mem_stall) begin
         if (q_rd.size() == 0) unexpected("rd_strobe");
         else chk("rd_addr", mem_addr, q_rd.pop_front());
      end
      if (c_write && c_src_mem) begin
         if (q_ins.size() == 0) unexpected("install");
         else begin
            ie = q_ins.pop_front();
            chk("ins_en", c_en, ie[3:2]);
            chk("ins_off", c_offset, ie[1:0]);
            chk("ins_valid", c_valid_in, 1);
         end
      end
      if (done) begin
         if (q_done.size() == 0) unexpected("done");
         else begin
            de = q_done.pop_front();
            chk("done_cycle", cyc, de / 2);
            chk("done_hit", cache_hit, de % 2);
            chk("done_stall", stall, 0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic r, input logic w, input logic [15:0] a, output int c0);
      tick();
      rd = r; wr = w; addr = a; c0 = cyc;
      tick();
      rd = 1'b0; wr = 1'b0;
   endtask

   task automatic at_cyc(input int n);
      while (cyc < n) tick();
   endtask

   task automatic exp_fill(input logic [15:0] a, input logic [1:0] en);
      for (int i = 0; i < 4; i++) begin
         logic [1:0] o;
         o = 2'(i);
         q_rd.push_back({a[15:3], o, 1'b0});
         q_ins.push_back({en, o});
      end
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while ((q_done.size() + q_rd.size() + q_wr.size() + q_ins.size()) != 0 && k < 60) begin
         tick();
         k++;
      end
      chk({name, "_pending"}, q_done.size() + q_rd.size() + q_wr.size() + q_ins.size(), 0);
      tick();
      chk({name, "_idle_stall"}, stall, 0);
   endtask

   initial begin
      int c0;
      repeat (2) tick();
      chk("rst_outs", {stall, done, err, mem_rd, mem_wr, c_en, c_write, c_comp, cache_hit, mem_addr}, 0);
      chk("rst_cnt", {hit_cnt, miss_cnt}, 0);
      rst_n = 1'b1;
      // read hit on way 1
      c_valid = 2'b10; c_hit = 2'b10;
      issue(1'b1, 1'b0, 16'h0024, c0);
      q_done.push_back(2 * (c0 + 1) + 1);
      wait_idle("hit");
      // clean read miss, both ways invalid -> way 0, pointer becomes 1
      c_valid = 2'b00; c_hit = 2'b00;
      issue(1'b1, 1'b0, 16'h0024, c0);
      exp_fill(16'h0024, 2'b01);
      q_done.push_back(2 * (c0 + 8));
      wait_idle("clean");
      // dirty miss, both valid, pointer=1 -> write-back way 1, pointer back to 0
      c_valid = 2'b11; c_dirty = 2'b11; c_tag = 9'h1A5;
      issue(1'b1, 1'b0, 16'h0024, c0);
      for (int i = 0; i < 4; i++) q_wr.push_back(16'hD2A0 + 16'(2 * i));
      exp_fill(16'h0024, 2'b10);
      q_done.push_back(2 * (c0 + 12));
      wait_idle("dirty");
      // clean write miss to way 0 with mem_stall held 3 cycles on fill word 2
      c_dirty = 2'b00;
      issue(1'b0, 1'b1, 16'h1236, c0);
      exp_fill(16'h1236, 2'b01);
      q_done.push_back(2 * (c0 + 11));
      at_cyc(c0 + 4);
      mem_stall = 1'b1;
      at_cyc(c0 + 7);
      mem_stall = 1'b0;
      wait_idle("stall");
      // rd & wr together -> sticky ERR until reset
      issue(1'b1, 1'b1, 16'h0024, c0);
      for (int i = 0; i < 10; i++) begin
         chk("err_sticky", {err, stall, done}, 3'b110);
         tick();
      end
      rst_n = 1'b0;
      #1;
      chk("err_rst", {err, stall}, 0);
      tick();
      rst_n = 1'b1;
      // reset during write-back word 1 abandons the operation
      c_valid = 2'b11; c_dirty = 2'b11; c_hit = 2'b00;
      issue(1'b1, 1'b0, 16'h0024, c0);
      q_wr.push_back(16'hD2A0);
      at_cyc(c0 + 3);
      rst_n = 1'b0;
      #1;
      chk("wb_rst_outs", {mem_wr, mem_rd, stall, c_en, mem_addr}, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (10) tick();
      chk("wb_rst_pending", q_wr.size() + q_rd.size() + q_done.size(), 0);
      // two hits and one miss for the performance counters
      c_valid = 2'b10; c_hit = 2'b10; c_dirty = 2'b00;
      for (int i = 0; i < 2; i++) begin
         issue(1'b1, 1'b0, 16'h0024, c0);
         q_done.push_back(2 * (c0 + 1) + 1);
         wait_idle("perf_hit");
      end
      c_valid = 2'b00; c_hit = 2'b00;
      issue(1'b1, 1'b0, 16'h0024, c0);
      exp_fill(16'h0024, 2'b01);
      q_done.push_back(2 * (c0 + 8));
      wait_idle("perf_miss");
`ifdef CACHE_CTRL_PERF_CNT_EN
      chk("hit_cnt", hit_cnt, 2);
      chk("miss_cnt", miss_cnt, 1);
`else
      chk("hit_cnt", hit_cnt, 0);
      chk("miss_cnt", miss_cnt, 0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cache_ctrl_fsm.md
Name: cache_ctrl_fsm

Overview:
- Parametrised controller FSM for the set-associative cache in the memory system. It generalises the direct-mapped mem_system controller to 1 or 2 ways, configurable line size and configurable memory latency.
- Sequences compare, victim selection, write-back, line fill and retry.
- Drives the cache-array and banked-memory control signals, plus the CPU handshake (done/stall/cache_hit/err).
- Cache data/tag arrays and the memory model are external.

Parameters:
- ADDR_W, 16, address width in bits.
- WORDS, 4, words per line; power of 2, range 2..8.
- MEM_LAT, 2, cycles from an accepted mem_rd to read data being valid; range 1..4.
- WAYS, 2, associativity; legal values 1 or 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- rd  in  1  CPU read request.
- wr  in  1  CPU write request.
- addr  in  ADDR_W  CPU address; offset = addr[log2(WORDS):1].
- c_hit  in  WAYS  per-way tag match.
- c_valid  in  WAYS  per-way valid.
- c_dirty  in  WAYS  per-way dirty.
- c_tag  in  ADDR_W-log2(WORDS)-1-INDEX  victim-way tag, used for the write-back address.
- c_en  out  WAYS  way enables.
- c_comp  out  1  compare mode.
- c_write  out  1  array write.
- c_valid_in  out  1  valid bit written on install.
- c_offset  out  log2(WORDS)  word offset into the line.
- c_src_mem  out  1  array write data comes from memory (1) or CPU (0).
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_stall  in  1  memory cannot accept a request this cycle.
- done  out  1  operation complete.
- stall  out  1  controller busy.
- cache_hit  out  1  completion was a first-pass hit.
- err  out  1  sticky error.
- hit_cnt  out  16  hit count.
- miss_cnt  out  16  miss count.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - All outputs 0, including counters.
  - victim pointer=0; fill tracker cleared.
  - Reset mid-fill or mid-write-back abandons the operation; no further mem strobes are issued.
- States: IDLE, COMP, WB, FILL, DRAIN, RETRY, ERR.
- IDLE:
  - stall=0.
  - rd^wr: latch addr and op, go to COMP.
  - rd&wr: go to ERR.
  - Neither: stay in IDLE.
- COMP:
  - c_comp=1; c_write=op_wr; c_en = all ways.
  - Hit: any way with c_hit&c_valid.
    - done=1, cache_hit=1, stall=0 in this same cycle; next state IDLE.
    - Read-hit latency is 1 cycle after acceptance.
  - Miss: stall=1; select victim.
    - Victim is the lowest-index invalid way if one exists.
    - Otherwise the way given by the victim pointer; WAYS=1 always selects way 0.
    - Victim dirty and valid: go to WB. Otherwise go to FILL.
- WB:
  - Per word, mem_wr=1 with mem_addr={c_tag, index, count, 0}; c_offset=count.
  - count advances only when mem_stall=0.
  - After word WORDS-1 is accepted: go to FILL with count cleared.
- FILL:
  - mem_rd=1 for word count; count advances when mem_stall=0.
  - Every accepted read pushes {offset} into the MEM_LAT-deep tracker.
  - After the last word is accepted: go to DRAIN.
- Install: when a tracker entry emerges, for the victim way:
  - c_write=1, c_src_mem=1, c_offset=entry, c_valid_in=1.
  - Install may overlap FILL.
- DRAIN:
  - Waits until the tracker is empty, then goes to RETRY.
- RETRY:
  - c_comp=1 with the original op; this is guaranteed to hit.
  - done=1, cache_hit=0, stall=0; victim pointer toggles; next state IDLE.
- Clean-miss latency (no mem_stall): 1 + WORDS + MEM_LAT + 1 cycles. A dirty miss adds WORDS.
- stall=1 in every state except IDLE, the COMP-hit cycle and RETRY.
- rd/wr asserted while stall=1 are ignored; they are not queued.
- ERR:
  - err=1, stall=1, done=0.
  - Exit only via reset.
  - An illegal state encoding also goes to ERR.
- Count wraps modulo WORDS. mem_addr is bits concatenated with no arithmetic overflow.

Optional Feature:
- Macro CACHE_CTRL_PERF_CNT_EN.
- When defined:
  - hit_cnt increments on each COMP-hit done.
  - miss_cnt increments on each COMP-miss cycle.
  - Both are 16-bit and saturate at 16'hFFFF.
- When undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package cache_ctrl_pkg:
  - state enum with encodings ERR=0, IDLE=1 ... RETRY=6.
  - localparams OFF_W=$clog2(WORDS) and a WAYS legality check.
- Sub-module cache_fill_tracker:
  - MEM_LAT-stage shift register of {valid, offset}.
  - Outputs: emerge, emerge_offset, empty.

Test Plan:
- Read hit, way 1 valid (WORDS=4, MEM_LAT=2): rd, addr=16'h0024 → COMP next cycle; done=1, cache_hit=1, stall=0 that same cycle; then IDLE.
- Clean read miss, both ways invalid, no mem_stall: 4 mem_rd pulses at offsets 0..3; 4 installs into way 0; done=1, cache_hit=0 in cycle 8 after acceptance.
- Dirty miss, both ways valid, victim pointer=1, c_tag=9'h1A5: 4 mem_wr pulses with mem_addr=16'hD2x0..x6 pattern, then fill; done in cycle 12; victim pointer becomes 0.
- mem_stall held 3 cycles during FILL word 2: count holds at 2; no duplicate tracker push; done delayed by exactly 3 cycles.
- rd=wr=1 in IDLE → ERR; err=1 persists for 10 cycles; rst_n pulse low → IDLE, err=0.
- rst_n asserted low during WB word 1: outputs 0 immediately; no mem_wr after release. With CACHE_CTRL_PERF_CNT_EN defined: 2 hits + 1 miss give hit_cnt=2, miss_cnt=1.
